// File: rtl/chime_controller.sv
// chime_controller
// Seatbelt warning chime sequencer. A qualified (debounced) alarm request
// drives a train of MAX_BEEPS beeps of ON_CYC cycles high / OFF_CYC cycles
// low. After the train, or when the driver mutes it, the block holds the lamp
// on and the chime off until the request goes away.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   alarm      - warning request (registered once before use)
//   mute       - driver silence request, sampled every cycle
//   chime      - registered beeper drive (high only while beeping)
//   lamp       - registered dashboard lamp (on while beeping or holding)
//   beep_count - registered number of beeps started in this alarm episode
module chime_controller #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int ON_CYC       = 8,
  parameter int OFF_CYC      = 8,
  parameter int MAX_BEEPS    = 6,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm,
  input  logic       mute,
  output logic       chime,
  output logic       lamp,
  output logic [3:0] beep_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUAL     = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [3:0]       BEEP_MAX = 4'(MAX_BEEPS);

  state_t           state;
  state_t           state_next;
  logic             alarm_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             chime_next;
  logic             lamp_next;
  logic [3:0]       beep_count_next;

  // State register. Outputs are registered alongside the state so that they
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q    <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      chime      <= 1'b0;
      lamp       <= 1'b0;
      beep_count <= 4'd0;
    end else begin
      alarm_q    <= alarm;
      state      <= state_next;
      cnt        <= cnt_next;
      chime      <= chime_next;
      lamp       <= lamp_next;
      beep_count <= beep_count_next;
    end
  end

  // Next-state logic. A dropped request always wins over mute.
  // In QUAL the counter holds the number of qualifying cycles already seen;
  // leaving once it reaches DEBOUNCE_CYC places the first chime edge at
  // DEBOUNCE_CYC+2 edges after the alarm is first sampled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (alarm_q) state_next = QUAL;
      end
      QUAL: begin
        if (!alarm_q)             state_next = IDLE;
        else if (cnt == DEB_LAST) state_next = BEEP_ON;
      end
      BEEP_ON: begin
        if (!alarm_q)            state_next = IDLE;
        else if (mute)           state_next = HOLD;
        else if (cnt == ON_LAST) state_next = BEEP_OFF;
      end
      BEEP_OFF: begin
        if (!alarm_q)       state_next = IDLE;
        else if (mute)      state_next = HOLD;
        else if (cnt == OFF_LAST) begin
          if (beep_count < BEEP_MAX) state_next = BEEP_ON;
          else                       state_next = HOLD;
        end
      end
      HOLD: begin
        if (!alarm_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath logic, derived from the state being entered.
  always_comb begin
    cnt_next        = cnt;
    chime_next      = 1'b0;
    lamp_next       = 1'b0;
    beep_count_next = beep_count;

    // Phase counter clears on every state change and saturates otherwise.
    if (state_next != state) cnt_next = '0;
    else if (cnt != '1)      cnt_next = cnt + CNT_W'(1);

    chime_next = (state_next == BEEP_ON);
    lamp_next  = (state_next == BEEP_ON) || (state_next == BEEP_OFF) ||
                 (state_next == HOLD);

    if (state_next == IDLE)
      beep_count_next = 4'd0;
    else if (state_next == BEEP_ON && state != BEEP_ON)
      beep_count_next = beep_count + 4'd1;
  end

endmodule

// File: tb/tb_chime_controller.sv
module tb_chime_controller;

  logic       clk;
  logic       rst;
  logic       alarm;
  logic       mute;
  logic       chime;
  logic       lamp;
  logic [3:0] beep_count;

  int total;
  int bad;

  chime_controller dut (
    .clk        (clk),
    .rst        (rst),
    .alarm      (alarm),
    .mute       (mute),
    .chime      (chime),
    .lamp       (lamp),
    .beep_count (beep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic c, input logic l, input logic [3:0] n);
    check({tag, ".chime"}, {3'b0, chime}, {3'b0, c});
    check({tag, ".lamp"},  {3'b0, lamp},  {3'b0, l});
    check({tag, ".count"}, beep_count, n);
  endtask

  // Alarm (already or newly) high: edges 0..5 silent, chime rises at edge 6.
  // Returns right after edge 6 (first BEEP_ON cycle).
  task automatic raise_to_first_beep(input string tag);
    alarm = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      check_outs({tag, ".debounce"}, 1'b0, 1'b0, 4'd0);
    end
    step();
    check_outs({tag, ".first_beep"}, 1'b1, 1'b1, 4'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    alarm = 1'b1;
    mute  = 1'b0;

    // Reset with alarm held: outputs stay low throughout.
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("reset_hold", 1'b0, 1'b0, 4'd0);
    end
    rst = 1'b0;
    raise_to_first_beep("after_reset");

    // Held alarm: 6 beeps of 8 on / 8 off, then HOLD. k counts edges since
    // the first beep edge (k=0 already checked).
    for (int k = 1; k <= 130; k++) begin
      logic       exp_c;
      logic [3:0] exp_n;
      step();
      exp_c = (k < 96) && ((k % 16) < 8);
      exp_n = (k < 96) ? 4'(k / 16 + 1) : 4'd6;
      check_outs($sformatf("train.k%0d", k), exp_c, 1'b1, exp_n);
    end

    // Drop alarm: one edge to register it, next edge to IDLE.
    alarm = 1'b0;
    step();
    check_outs("drop_hold.lag", 1'b0, 1'b1, 4'd6);
    step();
    check_outs("drop_hold.idle", 1'b0, 1'b0, 4'd0);

    // Short 3-cycle pulse never qualifies.
    alarm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("pulse.high", 1'b0, 1'b0, 4'd0);
    end
    alarm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_outs("pulse.after", 1'b0, 1'b0, 4'd0);
    end

    // Mute one cycle during the 2nd beep.
    raise_to_first_beep("mute");
    for (int k = 1; k <= 18; k++) step();
    check_outs("mute.second_on", 1'b1, 1'b1, 4'd2);
    mute = 1'b1;
    step();
    check_outs("mute.hold", 1'b0, 1'b1, 4'd2);
    mute = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      check_outs("mute.stay", 1'b0, 1'b1, 4'd2);
    end
    alarm = 1'b0;
    step();
    step();
    check_outs("mute.drop", 1'b0, 1'b0, 4'd0);

    // Drop alarm during the 3rd beep with mute in the cycle alarm_q falls.
    raise_to_first_beep("drop3");
    for (int k = 1; k <= 34; k++) step();
    check_outs("drop3.third_on", 1'b1, 1'b1, 4'd3);
    alarm = 1'b0;
    step();
    check_outs("drop3.lag", 1'b1, 1'b1, 4'd3);
    mute = 1'b1;
    step();
    check_outs("drop3.idle", 1'b0, 1'b0, 4'd0);
    mute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("drop3.quiet", 1'b0, 1'b0, 4'd0);
    end
    raise_to_first_beep("drop3.reraise");

    // Asynchronous reset in BEEP_OFF of the 1st beep.
    for (int k = 1; k <= 10; k++) step();
    check_outs("areset.off", 1'b0, 1'b1, 4'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outs("areset.async", 1'b0, 1'b0, 4'd0);
    step();
    check_outs("areset.held", 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    raise_to_first_beep("areset.requal");

    alarm = 1'b0;
    step();
    step();
    check_outs("final.idle", 1'b0, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chime_controller.md
CHIME_CONTROLLER -- requirements
Module: chime_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 4, meaning the number of consecutive cycles the registered Alarm must be high before chiming starts.
REQ-002 The block SHALL have parameter ON_CYC, default 8, meaning the number of cycles Chime stays high per beep.
REQ-003 The block SHALL have parameter OFF_CYC, default 8, meaning the number of cycles Chime stays low between beeps.
REQ-004 The block SHALL have parameter MAX_BEEPS, default 6, meaning the number of beeps before the chime is silenced; legal range is 1..15.
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning the phase counter width; DEBOUNCE_CYC, ON_CYC and OFF_CYC SHALL each lie in 1..2^CNT_W-1.
REQ-006 Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Alarm, input, 1 bit: seatbelt warning request from the car-warning logic (DoorClose & Ignition & ~SeatBelt).
REQ-009 Mute, input, 1 bit: driver silence request, sampled each cycle.
REQ-010 Chime, output, 1 bit, registered: audible beeper drive.
REQ-011 Lamp, output, 1 bit, registered: dashboard warning lamp.
REQ-012 BeepCount, output, 4 bits, registered: number of beeps started in the current alarm episode.

Function
REQ-013 Alarm SHALL be registered once (AlarmQ) before use; the FSM SHALL act only on AlarmQ.
REQ-014 The FSM SHALL have exactly these states: IDLE, QUAL, BEEP_ON, BEEP_OFF, HOLD.
REQ-015 IDLE SHALL go to QUAL when AlarmQ=1, clearing the phase counter.
REQ-016 In QUAL, AlarmQ=0 SHALL return to IDLE; after DEBOUNCE_CYC consecutive AlarmQ=1 cycles the FSM SHALL go to BEEP_ON.
REQ-017 With Alarm sampled high at edge 0 and held, Chime SHALL first be high after edge DEBOUNCE_CYC+2 (edge 6 at default).
REQ-018 Each entry to BEEP_ON SHALL increment BeepCount by 1.
REQ-019 BEEP_ON SHALL last exactly ON_CYC cycles, then go to BEEP_OFF.
REQ-020 BEEP_OFF SHALL last exactly OFF_CYC cycles.
REQ-021 At the end of BEEP_OFF, the FSM SHALL go to BEEP_ON if BeepCount<MAX_BEEPS, else to HOLD.
REQ-022 Chime SHALL be 1 only in BEEP_ON.
REQ-023 Lamp SHALL be 1 in BEEP_ON, BEEP_OFF and HOLD, and 0 in IDLE and QUAL.
REQ-024 Mute=1 in BEEP_ON or BEEP_OFF SHALL go to HOLD at the next edge, with Chime low from that edge and BeepCount held.
REQ-025 Mute SHALL have no effect in IDLE, QUAL or HOLD.
REQ-026 In HOLD, the FSM SHALL stay until AlarmQ=0.
REQ-027 AlarmQ=0 in any of BEEP_ON, BEEP_OFF or HOLD SHALL go to IDLE at the next edge, with Chime=0, Lamp=0 and BeepCount=0.
REQ-028 If AlarmQ=0 and Mute=1 occur in the same cycle, the AlarmQ=0 transition to IDLE SHALL take priority.
REQ-029 BeepCount SHALL never exceed MAX_BEEPS.
REQ-030 Phase counters SHALL never wrap; each counter SHALL clear on every state change.
REQ-031 Re-raising Alarm after a return to IDLE SHALL restart the full debounce, with BeepCount restarting from 0.

Reset
REQ-032 Rst=1 SHALL immediately, without waiting for Clk, force state=IDLE, AlarmQ=0, counters=0, Chime=0, Lamp=0 and BeepCount=0.
REQ-033 Reset assertion mid-beep SHALL silence Chime in the same cycle; after release, the FSM SHALL resume from IDLE and require a full debounce before chiming.

Verification
REQ-034 Assert Rst with Alarm=1 held -> Chime=0, Lamp=0 and BeepCount=0 throughout reset; after release, Chime rises at the 6th edge.
REQ-035 Pulse Alarm high for 3 cycles -> Chime=0, Lamp=0 and BeepCount=0 throughout.
REQ-036 Hold Alarm high for 200 cycles -> 6 beeps of 8 cycles high and 8 cycles low, BeepCount steps 1..6, then HOLD with Lamp=1, Chime=0 and BeepCount=6.
REQ-037 Mute=1 for 1 cycle during the 2nd BEEP_ON -> Chime=0 from the next edge, Lamp=1, and BeepCount stays 2 until Alarm drops.
REQ-038 Drop Alarm mid the 3rd BEEP_ON, with Mute=1 in the same cycle as AlarmQ falls -> IDLE with all outputs 0; re-raising Alarm brings the first Chime 6 edges later with BeepCount=1.
REQ-039 Assert Rst asynchronously mid BEEP_OFF -> outputs 0 before the next Clk edge, and no beep after release until Alarm re-qualifies.
